ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register for the single-issue datapath. Carries control bits, ALU result,
//  store data, destination register, next PC and branch target through STAGES register slices.
//  Adds valid tracking, stall (hold), flush (bubble insertion), a registered branch/jump redirect decision
//  and a saturating bubble counter for performance monitoring.
// PARAMETERS
//  DATA_W      32  width of alu_result, read_data2, next_pc, branch_target
//  REG_ADDR_W  5   width of destination register index
//  STAGES      1   number of slices (1..4); latency in unstalled cycles
//  CNT_W       16  width of bubble counter
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           synchronous reset, active-high
//  stall            in   1           hold all slices this cycle
//  flush            in   1           invalidate all slices this cycle
//  valid_i          in   1           incoming instruction is real
//  jump_i           in   1           jump control
//  branch_i         in   1           conditional branch control
//  mem_read_i       in   1           load control
//  mem_to_reg_i     in   1           writeback select control
//  mem_write_i      in   1           store control
//  reg_write_i      in   1           register write control
//  zf_i             in   1           ALU zero flag
//  next_pc_i        in   DATA_W      PC+4 of instruction
//  branch_target_i  in   DATA_W      computed branch/jump target
//  alu_result_i     in   DATA_W      ALU result / address
//  read_data2_i     in   DATA_W      store data
//  write_reg_i      in   REG_ADDR_W  destination register
//  valid_o          out  1           last slice holds real instruction
//  jump_o, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, reg_write_o, zf_o  out 1  registered copies
//  next_pc_o, branch_target_o, alu_result_o, read_data2_o  out DATA_W  registered copies
//  write_reg_o      out  REG_ADDR_W  registered copy
//  pc_src_o         out  1           redirect fetch: valid_o & (jump_o | (branch_o & zf_o))
//  bubble_cnt_o     out  CNT_W       saturating count of bubbles entering slice 0
// BEHAVIOUR
//  - Single clock clk; reset rst synchronous, active-high. All state updates on posedge clk only.
//  - Priority per cycle: rst > flush > stall > normal load.
//  - rst: every slice valid=0, all control/data fields=0, bubble_cnt=0. All outputs read 0 next cycle.
//  - flush: all slices valid=0 and control fields=0; data fields=0. bubble_cnt += 1 (one bubble per cycle).
//    flush with stall: flush wins.
//  - stall (no flush): every slice holds; bubble_cnt unchanged; inputs ignored.
//  - normal: slice0 <= inputs, slice k <= slice k-1; outputs driven from slice STAGES-1.
//  - Slice0 capture: when valid_i=0, control fields stored as 0 (data captured as-is); bubble_cnt += 1.
//  - Control outputs gated: whenever valid_o=0, jump_o..reg_write_o and pc_src_o are 0.
//  - pc_src_o combinational from last slice; no extra cycle beyond STAGES.
//  - Latency: STAGES edges from capture to output, plus one per stalled cycle.
//  - bubble_cnt saturates at 2^CNT_W-1; never wraps.
//  - STAGES outside 1..4: elaboration error.
//  - Reset mid-stall or mid-flush: reset result only; no residual state.
// TESTING
//  1 STAGES=1: rst high 2 cycles -> all outputs 0, bubble_cnt_o=0; release, load alu_result_i=0x1234, reg_write_i=1,
//    valid_i=1 -> next cycle alu_result_o=0x1234, reg_write_o=1, valid_o=1.
//  2 branch_i=1, zf_i=1, branch_target_i=0x40, valid_i=1 -> next cycle pc_src_o=1, branch_target_o=0x40;
//    same with zf_i=0 -> pc_src_o=0; jump_i=1, zf_i=0 -> pc_src_o=1.
//  3 load A (alu 0xA), stall 3 cycles with input B present -> outputs stay A for 3 cycles, B appears after stall drops.
//  4 STAGES=3: load A,B,C in consecutive cycles, flush together with D -> next cycle valid_o=0, all control 0,
//    bubble_cnt_o=1; D never appears at output.
//  5 valid_i=0 with mem_write_i=1 -> mem_write_o=0, valid_o=0, bubble_cnt_o increments; CNT_W=2, 5 bubbles -> count 3.
//  6 stall and flush asserted together -> flush behaviour; rst asserted with flush -> bubble_cnt_o=0.

Source files
------------

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM pipeline register bus.
// master: EX-stage side (drives stall/flush and the *_i payload, observes the *_o payload).
// slave : the pipeline register itself.
// Ports: stall, flush, valid_i, control bits, zf_i, next_pc_i, branch_target_i,
//        alu_result_i, read_data2_i, write_reg_i; the matching *_o copies, pc_src_o and bubble_cnt_o.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  stall;
  logic                  flush;
  logic                  valid_i;
  logic                  jump_i;
  logic                  branch_i;
  logic                  mem_read_i;
  logic                  mem_to_reg_i;
  logic                  mem_write_i;
  logic                  reg_write_i;
  logic                  zf_i;
  logic [DATA_W-1:0]     next_pc_i;
  logic [DATA_W-1:0]     branch_target_i;
  logic [DATA_W-1:0]     alu_result_i;
  logic [DATA_W-1:0]     read_data2_i;
  logic [REG_ADDR_W-1:0] write_reg_i;

  logic                  valid_o;
  logic                  jump_o;
  logic                  branch_o;
  logic                  mem_read_o;
  logic                  mem_to_reg_o;
  logic                  mem_write_o;
  logic                  reg_write_o;
  logic                  zf_o;
  logic [DATA_W-1:0]     next_pc_o;
  logic [DATA_W-1:0]     branch_target_o;
  logic [DATA_W-1:0]     alu_result_o;
  logic [DATA_W-1:0]     read_data2_o;
  logic [REG_ADDR_W-1:0] write_reg_o;
  logic                  pc_src_o;
  logic [CNT_W-1:0]      bubble_cnt_o;

  modport master (
    output stall, flush, valid_i, jump_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i,
           reg_write_i, zf_i, next_pc_i, branch_target_i, alu_result_i, read_data2_i, write_reg_i,
    input  valid_o, jump_o, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, reg_write_o, zf_o,
           next_pc_o, branch_target_o, alu_result_o, read_data2_o, write_reg_o, pc_src_o,
           bubble_cnt_o
  );

  modport slave (
    input  stall, flush, valid_i, jump_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i,
           reg_write_i, zf_i, next_pc_i, branch_target_i, alu_result_i, read_data2_i, write_reg_i,
    output valid_o, jump_o, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, reg_write_o, zf_o,
           next_pc_o, branch_target_o, alu_result_o, read_data2_o, write_reg_o, pc_src_o,
           bubble_cnt_o
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: STAGES slices with valid tracking, stall (hold), flush (bubble
// insertion), branch/jump redirect from the last slice and a saturating bubble counter.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (ex_mem_pipe_reg_if.slave).
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_mem_pipe_reg_if.slave     bus
);
  localparam int unsigned LAST = STAGES - 1;

  // Depth outside 1..4 is not a supported configuration.
  if (STAGES < 1 || STAGES > 4) begin : gBadStages
    $error("ex_mem_pipe_reg: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic                  valid;
    logic                  jump;
    logic                  branch;
    logic                  memRead;
    logic                  memToReg;
    logic                  memWrite;
    logic                  regWrite;
    logic                  zf;
    logic [DATA_W-1:0]     nextPc;
    logic [DATA_W-1:0]     branchTarget;
    logic [DATA_W-1:0]     aluResult;
    logic [DATA_W-1:0]     readData2;
    logic [REG_ADDR_W-1:0] writeReg;
  } sliceT;

  sliceT            pipe [STAGES];
  sliceT            captureSlice;
  logic [CNT_W-1:0] bubbleCnt;
  logic             bubbleInc;

  // Slice-0 payload: a non-valid instruction carries no control, so downstream never acts on it.
  always_comb begin
    captureSlice              = '0;
    captureSlice.valid        = bus.valid_i;
    captureSlice.jump         = bus.valid_i & bus.jump_i;
    captureSlice.branch       = bus.valid_i & bus.branch_i;
    captureSlice.memRead      = bus.valid_i & bus.mem_read_i;
    captureSlice.memToReg     = bus.valid_i & bus.mem_to_reg_i;
    captureSlice.memWrite     = bus.valid_i & bus.mem_write_i;
    captureSlice.regWrite     = bus.valid_i & bus.reg_write_i;
    captureSlice.zf           = bus.zf_i;
    captureSlice.nextPc       = bus.next_pc_i;
    captureSlice.branchTarget = bus.branch_target_i;
    captureSlice.aluResult    = bus.alu_result_i;
    captureSlice.readData2    = bus.read_data2_i;
    captureSlice.writeReg     = bus.write_reg_i;
  end

  // One bubble per flush cycle, or per unstalled cycle that loads a non-valid instruction.
  always_comb begin
    bubbleInc = bus.flush | (~bus.stall & ~bus.valid_i);
  end

  // Slice shift register; priority rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) pipe[k] <= '0;
      bubbleCnt <= '0;
    end else begin
      if (bus.flush) begin
        for (int unsigned k = 0; k < STAGES; k++) pipe[k] <= '0;
      end else if (!bus.stall) begin
        pipe[0] <= captureSlice;
        for (int unsigned k = 1; k < STAGES; k++) pipe[k] <= pipe[k-1];
      end
      if (bubbleInc && !(&bubbleCnt)) bubbleCnt <= bubbleCnt + CNT_W'(1);
    end
  end

  // Control fields are already zero whenever valid is zero, so no extra output gating is needed.
  assign bus.valid_o         = pipe[LAST].valid;
  assign bus.jump_o          = pipe[LAST].jump;
  assign bus.branch_o        = pipe[LAST].branch;
  assign bus.mem_read_o      = pipe[LAST].memRead;
  assign bus.mem_to_reg_o    = pipe[LAST].memToReg;
  assign bus.mem_write_o     = pipe[LAST].memWrite;
  assign bus.reg_write_o     = pipe[LAST].regWrite;
  assign bus.zf_o            = pipe[LAST].zf;
  assign bus.next_pc_o       = pipe[LAST].nextPc;
  assign bus.branch_target_o = pipe[LAST].branchTarget;
  assign bus.alu_result_o    = pipe[LAST].aluResult;
  assign bus.read_data2_o    = pipe[LAST].readData2;
  assign bus.write_reg_o     = pipe[LAST].writeReg;
  assign bus.bubble_cnt_o    = bubbleCnt;

  // Redirect decision straight off the last slice, no extra register stage.
  assign bus.pc_src_o = pipe[LAST].valid & (pipe[LAST].jump | (pipe[LAST].branch & pipe[LAST].zf));
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench: dutA (STAGES=1), dutB (STAGES=3), dutC (STAGES=1, CNT_W=2).
module tb_ex_mem_pipe_reg;
  logic clk;
  logic rstA;
  logic rstB;
  logic rstC;
  int   errors;
  int   checks;

  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) busA ();
  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) busB ();
  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2))  busC ();

  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rstA), .bus(busA.slave));
  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(3), .CNT_W(16)) dutB (
    .clk(clk), .rst(rstB), .bus(busB.slave));
  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(1), .CNT_W(2)) dutC (
    .clk(clk), .rst(rstC), .bus(busC.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleA();
    busA.stall = 0; busA.flush = 0; busA.valid_i = 0; busA.jump_i = 0; busA.branch_i = 0;
    busA.mem_read_i = 0; busA.mem_to_reg_i = 0; busA.mem_write_i = 0; busA.reg_write_i = 0;
    busA.zf_i = 0; busA.next_pc_i = '0; busA.branch_target_i = '0; busA.alu_result_i = '0;
    busA.read_data2_i = '0; busA.write_reg_i = '0;
  endtask

  task automatic idleB();
    busB.stall = 0; busB.flush = 0; busB.valid_i = 0; busB.jump_i = 0; busB.branch_i = 0;
    busB.mem_read_i = 0; busB.mem_to_reg_i = 0; busB.mem_write_i = 0; busB.reg_write_i = 0;
    busB.zf_i = 0; busB.next_pc_i = '0; busB.branch_target_i = '0; busB.alu_result_i = '0;
    busB.read_data2_i = '0; busB.write_reg_i = '0;
  endtask

  task automatic idleC();
    busC.stall = 0; busC.flush = 0; busC.valid_i = 0; busC.jump_i = 0; busC.branch_i = 0;
    busC.mem_read_i = 0; busC.mem_to_reg_i = 0; busC.mem_write_i = 0; busC.reg_write_i = 0;
    busC.zf_i = 0; busC.next_pc_i = '0; busC.branch_target_i = '0; busC.alu_result_i = '0;
    busC.read_data2_i = '0; busC.write_reg_i = '0;
  endtask

  initial begin
    clk = 0; errors = 0; checks = 0;
    rstA = 1; rstB = 1; rstC = 1;
    idleA(); idleB(); idleC();

    // Reset held two cycles on A.
    tick(); tick();
    check("rst_valid",  32'(busA.valid_o), 32'd0);
    check("rst_alu",    busA.alu_result_o, 32'd0);
    check("rst_regwr",  32'(busA.reg_write_o), 32'd0);
    check("rst_pcsrc",  32'(busA.pc_src_o), 32'd0);
    check("rst_bubble", 32'(busA.bubble_cnt_o), 32'd0);

    // First real instruction, one-cycle latency.
    rstA = 0;
    busA.valid_i = 1; busA.alu_result_i = 32'h1234; busA.reg_write_i = 1;
    tick();
    check("load_alu",    busA.alu_result_o, 32'h1234);
    check("load_regwr",  32'(busA.reg_write_o), 32'd1);
    check("load_valid",  32'(busA.valid_o), 32'd1);
    check("load_bubble", 32'(busA.bubble_cnt_o), 32'd0);

    // Taken branch.
    idleA();
    busA.valid_i = 1; busA.branch_i = 1; busA.zf_i = 1; busA.branch_target_i = 32'h40;
    tick();
    check("br_taken_pcsrc", 32'(busA.pc_src_o), 32'd1);
    check("br_taken_tgt",   busA.branch_target_o, 32'h40);
    check("br_taken_brout", 32'(busA.branch_o), 32'd1);
    // Not-taken branch.
    busA.zf_i = 0;
    tick();
    check("br_nt_pcsrc", 32'(busA.pc_src_o), 32'd0);
    // Jump ignores zf.
    busA.branch_i = 0; busA.jump_i = 1;
    tick();
    check("jmp_pcsrc", 32'(busA.pc_src_o), 32'd1);
    check("jmp_jout",  32'(busA.jump_o), 32'd1);

    // Stall holds A while B waits at the input.
    idleA();
    busA.valid_i = 1; busA.alu_result_i = 32'hA;
    tick();
    check("stall_preload", busA.alu_result_o, 32'hA);
    busA.alu_result_i = 32'hB; busA.stall = 1;
    tick(); check("stall_hold1", busA.alu_result_o, 32'hA);
    tick(); check("stall_hold2", busA.alu_result_o, 32'hA);
    tick(); check("stall_hold3", busA.alu_result_o, 32'hA);
    check("stall_valid",  32'(busA.valid_o), 32'd1);
    check("stall_bubble", 32'(busA.bubble_cnt_o), 32'd0);
    busA.stall = 0;
    tick();
    check("stall_release", busA.alu_result_o, 32'hB);

    // Stall and flush together: flush wins.
    busA.alu_result_i = 32'hC; busA.reg_write_i = 1; busA.stall = 1; busA.flush = 1;
    tick();
    check("sf_valid",  32'(busA.valid_o), 32'd0);
    check("sf_regwr",  32'(busA.reg_write_o), 32'd0);
    check("sf_alu",    busA.alu_result_o, 32'd0);
    check("sf_bubble", 32'(busA.bubble_cnt_o), 32'd1);
    // Reset together with flush: reset result only.
    rstA = 1;
    tick();
    check("rf_bubble", 32'(busA.bubble_cnt_o), 32'd0);
    check("rf_valid",  32'(busA.valid_o), 32'd0);
    idleA();

    // STAGES=3: A,B,C back to back, then flush alongside D.
    rstB = 0;
    busB.valid_i = 1; busB.reg_write_i = 1; busB.mem_read_i = 1; busB.alu_result_i = 32'h1;
    tick();
    check("s3_lat1_valid", 32'(busB.valid_o), 32'd0);
    busB.alu_result_i = 32'h2;
    tick();
    check("s3_lat2_valid", 32'(busB.valid_o), 32'd0);
    busB.alu_result_i = 32'h3;
    tick();
    check("s3_A_out",   busB.alu_result_o, 32'h1);
    check("s3_A_valid", 32'(busB.valid_o), 32'd1);
    busB.alu_result_i = 32'h4; busB.flush = 1;
    tick();
    check("s3_fl_valid",  32'(busB.valid_o), 32'd0);
    check("s3_fl_regwr",  32'(busB.reg_write_o), 32'd0);
    check("s3_fl_memrd",  32'(busB.mem_read_o), 32'd0);
    check("s3_fl_alu",    busB.alu_result_o, 32'd0);
    check("s3_fl_bubble", 32'(busB.bubble_cnt_o), 32'd1);
    idleB();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_noD_valid", 32'(busB.valid_o), 32'd0);
      check("s3_noD_alu",   busB.alu_result_o, 32'd0);
    end
    check("s3_bubble_end", 32'(busB.bubble_cnt_o), 32'd4);

    // Invalid instruction drops control but keeps data; 2-bit counter saturates at 3.
    rstC = 0;
    busC.valid_i = 0; busC.mem_write_i = 1; busC.alu_result_i = 32'h55;
    tick();
    check("inv_memwr",  32'(busC.mem_write_o), 32'd0);
    check("inv_valid",  32'(busC.valid_o), 32'd0);
    check("inv_data",   busC.alu_result_o, 32'h55);
    check("inv_bubble", 32'(busC.bubble_cnt_o), 32'd1);
    tick(); check("sat_b2", 32'(busC.bubble_cnt_o), 32'd2);
    tick(); check("sat_b3", 32'(busC.bubble_cnt_o), 32'd3);
    tick(); check("sat_b4", 32'(busC.bubble_cnt_o), 32'd3);
    tick(); check("sat_b5", 32'(busC.bubble_cnt_o), 32'd3);
    busC.valid_i = 1;
    tick();
    check("val_memwr",  32'(busC.mem_write_o), 32'd1);
    check("val_bubble", 32'(busC.bubble_cnt_o), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
